branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Branch prediction stage directly upstream of instruction fetch.
- Each cycle it looks up the fetch-side next PC in a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters.
- It returns target_bp/target_en_bp to fetch, which selects the redirect in the same cycle.
- Execute writes resolved branch outcomes back through a one-cycle update port.

Parameters:
- IDX_BITS, 4: BTB index width; DEPTH = 2**IDX_BITS entries.
- PC_W, 16: PC and target width; tag width = PC_W - IDX_BITS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- lookup_pc  input  PC_W  next PC from fetch (fetch's next_program_counter_if_to_bp).
- target_bp  output  PC_W  predicted target for lookup_pc.
- target_en_bp  output  1  1 = redirect fetch to target_bp.
- update_en  input  1  execute reports a resolved branch this cycle.
- update_pc  input  PC_W  PC of the resolved branch.
- update_taken  input  1  actual direction.
- update_target  input  PC_W  actual taken target.
- hit_bp  output  1  lookup_pc matched a valid entry (debug/perf).

Behaviour:
Entry contents:
- Entry i holds valid, tag[PC_W-IDX_BITS-1:0], target[PC_W-1:0] and ctr[1:0].
- Index = pc[IDX_BITS-1:0]; tag = pc[PC_W-1:IDX_BITS].

Lookup (purely combinational from registered table state, zero latency):
- hit_bp = valid[idx] && tag[idx]==lookup tag.
- target_en_bp = hit_bp && ctr[idx][1].
- target_bp = target[idx] when target_en_bp, else 0.

Reset (reset==0 at posedge clk):
- All valid=0, ctr=2'b01, tag=0, target=0.
- Outputs therefore read target_en_bp=0, hit_bp=0, target_bp=0 from the first cycle after reset.
- Reset has priority over a same-cycle update, which is discarded.

Update (sampled at posedge clk when reset==1 and update_en==1; visible to lookup from the next cycle):
- Hit, taken: ctr = sat_inc(ctr); target = update_target.
- Hit, not taken: ctr = sat_dec(ctr); target unchanged.
- Miss, taken: allocate/overwrite entry: valid=1, tag=update tag, target=update_target, ctr=2'b10.
- Miss, not taken: no change. Not-taken branches are never allocated.

Counter:
- Encodings: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- sat_inc(11)=11; sat_dec(00)=00. No wrap.

Boundary conditions:
- Same-cycle lookup and update to the same index: lookup returns the pre-update state (no bypass).
- Aliasing: a different tag at the same index is a miss; a taken update evicts the old entry.
- Arithmetic: target stored verbatim; no PC+1 arithmetic in this block (fetch adds 1).
- update_en==0: table holds.
- X on update_* while update_en==0 must not corrupt state.

Decomposition:
- Package bp_pkg:
  - CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - PC_W default.
  - Typedef for the entry record {valid, tag, target, ctr}.
- Sub-module bp_sat_ctr2: combinational next-counter function (inputs ctr, taken; output next ctr), instantiated once on the update path.
- Table kept as flop arrays (asynchronous read required), not inferred RAM.

Test Plan:
- Reset: hold reset=0 for 2 cycles with update_en=1, update_pc=16'h0005, taken=1 -> after release, lookup_pc=16'h0005 gives hit_bp=0, target_en_bp=0, target_bp=0.
- Allocate: update_pc=16'h0013, taken=1, target=16'h0040 -> next cycle lookup 16'h0013 gives hit_bp=1, target_en_bp=1, target_bp=16'h0040. Lookup 16'h0023 (same index, tag differs) gives hit_bp=0.
- Hysteresis: after allocate (ctr=10), one not-taken update -> 01, target_en_bp=0, hit_bp=1. Two taken updates -> 11. Third taken stays 11. Three not-taken -> 00 and stays 00 on a fourth.
- Same-cycle hazard: entry 16'h0013 ctr=10; drive lookup 16'h0013 and not-taken update to 16'h0013 in the same cycle -> that cycle target_en_bp=1; next cycle 0.
- Eviction and target change: entry 16'h0013 -> taken update 16'h0023 target 16'h0077 gives lookup 16'h0013 miss and 16'h0023 hit with target 16'h0077, ctr=10. Taken update 16'h0023 target 16'h0099 then gives target_bp=16'h0099.
- Not-taken miss: update_pc=16'h0007, taken=0 on an invalid entry -> lookup 16'h0007 remains hit_bp=0. Mid-run reset=0 clears all previously valid entries.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared widths, counter encodings and BTB entry record
// for the branch target predictor.
package bp_pkg;

  localparam int IDX_BITS = 4;
  localparam int PC_W     = 16;
  localparam int TAG_W    = PC_W - IDX_BITS;
  localparam int DEPTH    = 1 << IDX_BITS;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef logic [PC_W-1:0]     pc_t;
  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [TAG_W-1:0]    tag_t;

  typedef struct packed {
    logic       valid;
    tag_t       tag;
    pc_t        target;
    logic [1:0] ctr;
  } bp_entry_t;

  function automatic idx_t pc_idx(input pc_t pc);
    return pc[IDX_BITS-1:0];
  endfunction

  function automatic tag_t pc_tag(input pc_t pc);
    return pc[PC_W-1:IDX_BITS];
  endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Fetch lookup and execute update bundle between the
// predictor and its neighbouring pipeline stages.
interface branch_target_predictor_if;
  import bp_pkg::*;

  pc_t  lookup_pc;
  pc_t  target_bp;
  logic target_en_bp;
  logic hit_bp;
  logic update_en;
  pc_t  update_pc;
  logic update_taken;
  pc_t  update_target;

  modport master (
    output lookup_pc,
    output update_en,
    output update_pc,
    output update_taken,
    output update_target,
    input  target_bp,
    input  target_en_bp,
    input  hit_bp
  );

  modport slave (
    input  lookup_pc,
    input  update_en,
    input  update_pc,
    input  update_taken,
    input  update_target,
    output target_bp,
    output target_en_bp,
    output hit_bp
  );

endinterface

// File: rtl/bp_sat_ctr2.sv
// Two-bit saturating direction counter, next-state only.
// Saturates at strong-NT and strong-T, never wraps.
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    unique case (1'b1)
      (i_taken && i_ctr != CTR_ST):
        o_ctr = i_ctr + 2'd1;
      (!i_taken && i_ctr != CTR_SNT):
        o_ctr = i_ctr - 2'd1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters; zero-latency lookup
// for fetch, single-cycle writeback from execute.
module branch_target_predictor
  import bp_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  branch_target_predictor_if.slave  bp
);

  bp_entry_t  r_tbl [DEPTH];

  idx_t       w_lk_idx;
  tag_t       w_lk_tag;
  bp_entry_t  w_lk_e;
  logic       w_lk_hit;

  idx_t       w_up_idx;
  tag_t       w_up_tag;
  bp_entry_t  w_up_e;
  logic       w_up_hit;
  logic [1:0] w_nxt_ctr;
  logic       w_up_wr;
  bp_entry_t  w_up_new;

  assign w_lk_idx = pc_idx(bp.lookup_pc);
  assign w_lk_tag = pc_tag(bp.lookup_pc);
  assign w_lk_e   = r_tbl[w_lk_idx];
  assign w_lk_hit = w_lk_e.valid
                 && (w_lk_e.tag == w_lk_tag);

  // Lookup sees only registered state: no update bypass.
  assign bp.hit_bp       = w_lk_hit;
  assign bp.target_en_bp = w_lk_hit && w_lk_e.ctr[1];
  assign bp.target_bp    = bp.target_en_bp
                         ? w_lk_e.target : '0;

  assign w_up_idx = pc_idx(bp.update_pc);
  assign w_up_tag = pc_tag(bp.update_pc);
  assign w_up_e   = r_tbl[w_up_idx];
  assign w_up_hit = w_up_e.valid
                 && (w_up_e.tag == w_up_tag);

  bp_sat_ctr2 u_ctr (
    .i_ctr   (w_up_e.ctr),
    .i_taken (bp.update_taken),
    .o_ctr   (w_nxt_ctr)
  );

  always_comb begin
    w_up_wr  = 1'b0;
    w_up_new = w_up_e;
    unique case (1'b1)
      (bp.update_en && w_up_hit): begin
        w_up_wr      = 1'b1;
        w_up_new.ctr = w_nxt_ctr;
        if (bp.update_taken)
          w_up_new.target = bp.update_target;
      end
      (bp.update_en && !w_up_hit
        && bp.update_taken): begin
        w_up_wr         = 1'b1;
        w_up_new.valid  = 1'b1;
        w_up_new.tag    = w_up_tag;
        w_up_new.target = bp.update_target;
        w_up_new.ctr    = CTR_WT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl[i].valid  <= 1'b0;
        r_tbl[i].tag    <= '0;
        r_tbl[i].target <= '0;
        r_tbl[i].ctr    <= CTR_WNT;
      end
    end else if (w_up_wr) begin
      r_tbl[w_up_idx] <= w_up_new;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed plus random bench for branch_target_predictor
// against an array-based reference of the BTB.
module tb_branch_target_predictor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_target_predictor_if bif ();

  branch_target_predictor dut (
    .clk   (clk),
    .reset (rst),
    .bp    (bif)
  );

  int n_chk = 0;
  int n_err = 0;

  int mv [16];
  int mt [16];
  int mg [16];
  int mc [16];

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 0; mt[i] = 0; mg[i] = 0; mc[i] = 1;
    end
  endtask

  task automatic model_update(input int pc,
                              input int tk,
                              input int tg);
    int ix, tt;
    ix = pc % 16;
    tt = pc / 16;
    if (mv[ix] != 0 && mt[ix] == tt) begin
      if (tk != 0) begin
        mc[ix] = (mc[ix] == 3) ? 3 : mc[ix] + 1;
        mg[ix] = tg;
      end else begin
        mc[ix] = (mc[ix] == 0) ? 0 : mc[ix] - 1;
      end
    end else if (tk != 0) begin
      mv[ix] = 1; mt[ix] = tt; mg[ix] = tg; mc[ix] = 2;
    end
  endtask

  // Advance one clock, mirroring what the table samples.
  task automatic step();
    @(posedge clk);
    if (rst == 1'b0)
      model_reset();
    else if (bif.update_en == 1'b1)
      model_update(int'(bif.update_pc),
                   int'(bif.update_taken),
                   int'(bif.update_target));
    #1;
    bif.update_en     = 1'b0;
    bif.update_pc     = 16'($urandom);
    bif.update_taken  = 1'($urandom);
    bif.update_target = 16'($urandom);
  endtask

  task automatic look(input logic [15:0] pc,
                      input string tag);
    int ix, tt, hit, en, tg;
    bif.lookup_pc = pc;
    #1;
    ix  = int'(pc) % 16;
    tt  = int'(pc) / 16;
    hit = (mv[ix] != 0 && mt[ix] == tt) ? 1 : 0;
    en  = (hit != 0 && mc[ix] >= 2) ? 1 : 0;
    tg  = (en != 0) ? mg[ix] : 0;
    check({tag, ".hit"}, 16'(bif.hit_bp), 16'(hit));
    check({tag, ".en"}, 16'(bif.target_en_bp), 16'(en));
    check({tag, ".tgt"}, bif.target_bp, 16'(tg));
  endtask

  task automatic drive_upd(input logic [15:0] pc,
                           input logic tk,
                           input logic [15:0] tg);
    bif.update_en     = 1'b1;
    bif.update_pc     = pc;
    bif.update_taken  = tk;
    bif.update_target = tg;
  endtask

  task automatic upd(input logic [15:0] pc,
                     input logic tk,
                     input logic [15:0] tg);
    drive_upd(pc, tk, tg);
    step();
  endtask

  initial begin
    model_reset();
    bif.lookup_pc = 16'h0;
    rst = 1'b0;
    // Updates during reset must be discarded.
    drive_upd(16'h0005, 1'b1, 16'h1234);
    @(posedge clk); #1;
    drive_upd(16'h0005, 1'b1, 16'h1234);
    step();
    rst = 1'b1;
    look(16'h0005, "reset");

    upd(16'h0013, 1'b1, 16'h0040);
    look(16'h0013, "alloc");
    check("alloc.tgt_abs", bif.target_bp, 16'h0040);
    look(16'h0023, "alias");

    upd(16'h0013, 1'b0, 16'h0);
    look(16'h0013, "hys_nt1");
    upd(16'h0013, 1'b1, 16'h0040);
    look(16'h0013, "hys_t1");
    upd(16'h0013, 1'b1, 16'h0040);
    look(16'h0013, "hys_t2");
    upd(16'h0013, 1'b1, 16'h0041);
    look(16'h0013, "hys_t3");
    upd(16'h0013, 1'b0, 16'h0);
    look(16'h0013, "hys_d1");
    upd(16'h0013, 1'b0, 16'h0);
    look(16'h0013, "hys_d2");
    upd(16'h0013, 1'b0, 16'h0);
    look(16'h0013, "hys_d3");
    upd(16'h0013, 1'b0, 16'h0);
    look(16'h0013, "hys_d4");
    upd(16'h0013, 1'b1, 16'h0042);
    look(16'h0013, "hys_up");
    check("hys_up.en_abs", 16'(bif.target_en_bp), 16'h0);

    upd(16'h0023, 1'b1, 16'h0011);
    upd(16'h0013, 1'b1, 16'h0040);
    drive_upd(16'h0013, 1'b0, 16'h0);
    look(16'h0013, "hazard_same");
    check("hazard.en_abs", 16'(bif.target_en_bp), 16'h1);
    step();
    look(16'h0013, "hazard_next");

    upd(16'h0023, 1'b1, 16'h0077);
    look(16'h0013, "evict_old");
    look(16'h0023, "evict_new");
    check("evict.tgt_abs", bif.target_bp, 16'h0077);
    upd(16'h0023, 1'b1, 16'h0099);
    look(16'h0023, "retarget");
    check("retarget.abs", bif.target_bp, 16'h0099);

    upd(16'h0007, 1'b0, 16'h0055);
    look(16'h0007, "nt_miss");

    for (int i = 0; i < 6; i++)
      step();
    look(16'h0023, "hold");

    rst = 1'b0;
    drive_upd(16'h0023, 1'b1, 16'h0abc);
    step();
    rst = 1'b1;
    look(16'h0023, "midrst_a");
    look(16'h0013, "midrst_b");

    for (int i = 0; i < 400; i++) begin
      logic [15:0] pc;
      pc = {14'($urandom_range(0, 3)), 2'b0}
         | 16'($urandom_range(0, 15));
      pc = {8'h0, 2'($urandom_range(0, 2)),
            2'b0, 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 3) != 0)
        drive_upd({8'h0, 2'($urandom_range(0, 2)),
                   2'b0, 4'($urandom_range(0, 15))},
                  1'($urandom), 16'($urandom));
      if ($urandom_range(0, 49) == 0)
        rst = 1'b0;
      look(pc, "rand");
      step();
      rst = 1'b1;
    end

    for (int i = 0; i < 16; i++)
      look(16'(i), "final_sweep");

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
